// File: rtl/switchbox_pkg.sv
// Shared definitions for the switch-box configuration path: geometry, side codes,
// address map bases and the loader state encoding.
package switchbox_pkg;

    localparam int N_TB      = 5;
    localparam int N_LR      = 4;
    localparam int WORD_W    = 6;
    localparam int NUM_WORDS = 2*N_TB + 2*N_LR;
    localparam int ADDR_W    = 5;

    localparam logic [7:0] SYNC = 8'hA5;

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam int TOP_BASE    = 0;
    localparam int BOTTOM_BASE = 5;
    localparam int LEFT_BASE   = 10;
    localparam int RIGHT_BASE  = 14;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LOAD,
        ST_CSUM,
        ST_EVAL,
        ST_COMMIT,
        ST_DONE
    } loader_state_e;

    // Side codes above SIDE_LEFT have no meaning in the switch box.
    function automatic logic side_illegal(input logic [WORD_W-1:0] word);
        return word[2:0] > SIDE_LEFT;
    endfunction

endpackage

// File: rtl/cfg_word_deser.sv
// Serial-to-word assembler: counts bits and words, emits each completed word
// combinationally together with the bit that completes it.
module cfg_word_deser
    import switchbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic [ADDR_W-1:0] word_idx_o,
    output logic              last_bit_o
);

    logic [2:0]        bit_cnt_q,  bit_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_W-2:0] shift_q,    shift_d;
    logic              word_end;
    logic              last_word;

    assign word_end     = (bit_cnt_q == 3'(WORD_W-1));
    assign last_word    = (word_cnt_q == ADDR_W'(NUM_WORDS-1));
    assign word_valid_o = bit_valid_i && !clr_i && word_end;
    assign word_o       = {shift_q, bit_i};
    assign word_idx_o   = word_cnt_q;
    assign last_bit_o   = word_valid_o && last_word;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        if (clr_i) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            shift_d    = '0;
        end else if (bit_valid_i) begin
            shift_d = {shift_q[WORD_W-3:0], bit_i};
            if (word_end) begin
                bit_cnt_d  = '0;
                word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Switch-box configuration loader: hunts for sync, stages a full frame, checks it,
// then commits all route words in one burst or rejects the whole frame.
//
// state     | meaning
// ST_HUNT   | shifting bits looking for the sync byte
// ST_LOAD   | receiving the 18 route words into staging
// ST_CSUM   | receiving the 6-bit checksum
// ST_EVAL   | one-cycle accept/reject decision
// ST_COMMIT | writing staged words to addresses 0..17
// ST_DONE   | commit-complete pulse
module switchbox_cfg_loader
    import switchbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_din,
    input  logic              ser_valid,
    output logic              ser_ready,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [WORD_W-1:0] cfg_data,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    loader_state_e     state_q,   state_d;
    logic [7:0]        sync_q,    sync_d;
    logic [WORD_W-1:0] csum_q,    csum_d;
    logic [WORD_W-1:0] rx_csum_q, rx_csum_d;
    logic              illegal_q, illegal_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [WORD_W-1:0] stage_q [NUM_WORDS];

    logic              in_frame;
    logic              accept;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] word_idx;
    logic              last_bit;

    assign in_frame  = (state_q == ST_LOAD) || (state_q == ST_CSUM);
    assign ser_ready = !rst && ((state_q == ST_HUNT) || in_frame);
    assign accept    = ser_valid && ser_ready;
    assign cfg_busy  = (state_q != ST_HUNT);

    cfg_word_deser u_deser (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (!in_frame),
        .bit_valid_i  (accept),
        .bit_i        (ser_din),
        .word_valid_o (word_valid),
        .word_o       (word),
        .word_idx_o   (word_idx),
        .last_bit_o   (last_bit)
    );

    always_comb begin
        state_d   = state_q;
        sync_d    = '0;
        csum_d    = csum_q;
        rx_csum_d = rx_csum_q;
        illegal_d = illegal_q;
        addr_d    = addr_q;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        cfg_done  = 1'b0;
        cfg_err   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                sync_d    = sync_q;
                csum_d    = '0;
                illegal_d = 1'b0;
                if (accept) begin
                    sync_d = {sync_q[6:0], ser_din};
                    if (sync_d == SYNC) state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    csum_d    = csum_q ^ word;
                    illegal_d = illegal_q | side_illegal(word);
                    if (last_bit) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (word_valid) begin
                    rx_csum_d = word;
                    state_d   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                addr_d = '0;
                if ((rx_csum_q == csum_q) && !illegal_q) begin
                    state_d = ST_COMMIT;
                end else begin
                    cfg_err = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            ST_COMMIT: begin
                cfg_we   = 1'b1;
                cfg_addr = addr_q;
                cfg_data = stage_q[addr_q];
                addr_d   = addr_q + 1'b1;
                if (addr_q == ADDR_W'(NUM_WORDS-1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                cfg_done = 1'b1;
                state_d  = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HUNT;
            sync_q    <= '0;
            csum_q    <= '0;
            rx_csum_q <= '0;
            illegal_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            csum_q    <= csum_d;
            rx_csum_q <= rx_csum_d;
            illegal_q <= illegal_d;
            addr_q    <= addr_d;
        end
    end

    // Staging holds the frame until it is proven good, so a reject leaves the box untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) stage_q[i] <= '0;
        end else if ((state_q == ST_LOAD) && word_valid) begin
            stage_q[word_idx] <= word;
        end
    end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Scoreboard bench for the switch-box config loader: frames are driven serially,
// a frame-level model queues the expected writes/done/err events with their cycles.
module tb_switchbox_cfg_loader;
    import switchbox_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_din;
    logic       ser_valid;
    logic       ser_ready;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // number of rising edges so far; the period after edge k has cyc==k
    bit mon_en = 1'b0;

    typedef struct {
        int kind;     // 0 write, 1 done, 2 err
        int addr;
        int data;
        int cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [5:0] frame_w [NUM_WORDS];

    switchbox_cfg_loader dut (
        .clk       (clk),
        .rst       (rst),
        .ser_din   (ser_din),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at cyc %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows an event.
    initial begin
        ev_t e;
        int  got;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("done_err_exclusive", int'(cfg_done && cfg_err), 0);
                if (cfg_we || cfg_done || cfg_err) begin
                    got = cfg_we ? 0 : (cfg_done ? 1 : 2);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got kind %0d addr %0d data %0d at cyc %0d, required none",
                                 got, cfg_addr, cfg_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", got, e.kind);
                        check("event_cycle", cyc, e.cyc);
                        if (got == 0) begin
                            check("write_addr", cfg_addr, e.addr);
                            check("write_data", cfg_data, e.data);
                        end
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_event: got nothing by cyc %0d, required kind %0d addr %0d at cyc %0d",
                             cyc, e.kind, e.addr, e.cyc);
                end
            end
        end
    end

    // Frame-level reference: checksum is the XOR of all words; any side code above 4 rejects.
    task automatic model_frame(input logic [5:0] rx_csum, input int t, input int abort_after, output bit ok);
        logic [5:0] x = '0;
        bit         bad_side = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            x ^= frame_w[i];
            if (int'(frame_w[i][2:0]) > 4) bad_side = 1'b1;
        end
        ok = (x == rx_csum) && !bad_side;
        if (ok) begin
            for (int i = 0; i < NUM_WORDS && i < abort_after; i++)
                exp_q.push_back('{0, i, int'(frame_w[i]), t + 1 + i});
            if (abort_after >= NUM_WORDS) exp_q.push_back('{1, 0, 0, t + 1 + NUM_WORDS});
        end else begin
            exp_q.push_back('{2, 0, 0, t});
        end
    endtask

    task automatic send_bit(input logic b, input bit stall, output int t_acc);
        int guard = 0;
        if (stall) begin
            ser_valid = 1'b0;
            @(negedge clk);
        end
        ser_valid = 1'b1;
        ser_din   = b;
        while (!ser_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ser_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ser_ready=0 for %0d cycles, required 1", guard);
        end
        t_acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [5:0] csum, input bit stall, input int abort_after,
                              output int t, output bit ok);
        logic [7:0] s = SYNC;
        logic [5:0] w;
        for (int i = 7; i >= 0; i--) send_bit(s[i], stall, t);
        for (int k = 0; k < NUM_WORDS; k++) begin
            w = frame_w[k];
            for (int i = 5; i >= 0; i--) send_bit(w[i], stall, t);
        end
        for (int i = 5; i >= 0; i--) send_bit(csum[i], stall, t);
        model_frame(csum, t, abort_after, ok);
    endtask

    // Keep a bit offered after the frame; it must not be taken until the loader is back in HUNT.
    task automatic hold_check(input int t, input bit ok);
        int last = ok ? t + NUM_WORDS + 1 : t;
        ser_valid = 1'b1;
        ser_din   = 1'b0;
        while (cyc <= last) begin
            check("ready_low_while_busy", ser_ready, 0);
            check("busy_high", cfg_busy, 1);
            @(negedge clk);
        end
        check("ready_back_in_hunt", ser_ready, 1);
        check("busy_low_in_hunt", cfg_busy, 0);
        ser_valid = 1'b0;
    endtask

    function automatic logic [5:0] xor_frame();
        logic [5:0] x = '0;
        for (int i = 0; i < NUM_WORDS; i++) x ^= frame_w[i];
        return x;
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < NUM_WORDS; i++) frame_w[i] = '0;
    endtask

    task automatic random_frame(input int mode, output logic [5:0] csum);
        for (int i = 0; i < NUM_WORDS; i++)
            frame_w[i] = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 4))};
        if (mode == 2) frame_w[$urandom_range(0, NUM_WORDS-1)][2:0] = 3'($urandom_range(5, 7));
        csum = xor_frame();
        if (mode == 1) csum ^= 6'(1 << $urandom_range(0, 5));
    endtask

    task automatic mixed_frame();
        clear_frame();
        frame_w[0]  = 6'h0A;
        frame_w[5]  = 6'h01;
        frame_w[16] = 6'h1C;
    endtask

    initial begin
        int         t;
        bit         ok;
        logic [5:0] cs;
        logic [7:0] noise;
        int         guard;

        rst       = 1'b1;
        ser_valid = 1'b0;
        ser_din   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ser_ready, 0);
        check("rst_we", cfg_we, 0);
        check("rst_addr", cfg_addr, 0);
        check("rst_data", cfg_data, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", ser_ready, 1);
        mon_en = 1'b1;
        @(negedge clk);

        // all-zero frame commits
        clear_frame();
        send_frame(6'h00, 1'b0, NUM_WORDS, t, ok);
        check("zero_frame_ok", ok, 1);
        hold_check(t, ok);

        // mixed frame, then the same payload with a bad checksum, then good again
        mixed_frame();
        send_frame(6'h17, 1'b0, NUM_WORDS, t, ok);
        check("mixed_frame_ok", ok, 1);
        hold_check(t, ok);
        send_frame(6'h16, 1'b0, NUM_WORDS, t, ok);
        check("bad_csum_rejected", ok, 0);
        hold_check(t, ok);
        send_frame(6'h17, 1'b0, NUM_WORDS, t, ok);
        hold_check(t, ok);

        // illegal side code with a matching checksum
        clear_frame();
        frame_w[3] = 6'h05;
        send_frame(6'h05, 1'b0, NUM_WORDS, t, ok);
        check("illegal_side_rejected", ok, 0);
        hold_check(t, ok);

        // noise that must not sync, then a stalled frame
        noise = 8'h5A;
        for (int i = 7; i >= 0; i--) send_bit(noise[i], 1'b1, t);
        ser_valid = 1'b0;
        check("noise_no_sync", cfg_busy, 0);
        random_frame(0, cs);
        send_frame(cs, 1'b1, NUM_WORDS, t, ok);
        hold_check(t, ok);

        // reset during the 7th write
        random_frame(0, cs);
        send_frame(cs, 1'b0, 7, t, ok);
        ser_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_we", cfg_we, 0);
        check("abort_busy", cfg_busy, 0);
        check("abort_done", cfg_done, 0);
        check("abort_ready", ser_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        mixed_frame();
        send_frame(6'h17, 1'b0, NUM_WORDS, t, ok);
        hold_check(t, ok);

        // randomized frames: good, bad checksum, illegal side; random stalling
        for (int n = 0; n < 12; n++) begin
            random_frame(int'($urandom_range(0, 2)), cs);
            send_frame(cs, 1'($urandom_range(0, 1)), NUM_WORDS, t, ok);
            hold_check(t, ok);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
